// File: rtl/vending_machine_gen2.sv
// Keypad-selected vending controller with a writable price table, saturating coin credit,
// cancel/refund, keypad timeout and greedy coin-by-coin change over a valid/ready handshake.
module vending_machine_gen2 #(
    parameter int N_ROWS        = 4,
    parameter int N_COLS        = 4,
    parameter int VAL_W         = 16,
    parameter int DEFAULT_PRICE = 100,
    parameter int TIMEOUT_CYC   = 1000,
    localparam int SEL_W        = $clog2(N_ROWS*N_COLS)
) (
    input  logic              I_CLK,
    input  logic              I_RESET,
    input  logic [N_ROWS-1:0] I_ROW,
    input  logic [N_COLS-1:0] I_COL,
    input  logic              I_COIN_VALID,
    input  logic [VAL_W-1:0]  I_COIN_VAL,
    input  logic              I_CANCEL,
    input  logic              I_PW_EN,
    input  logic [SEL_W-1:0]  I_PW_ADDR,
    input  logic [VAL_W-1:0]  I_PW_DATA,
    input  logic              I_COIN_OUT_READY,
    output logic [VAL_W-1:0]  O_CREDIT,
    output logic [VAL_W-1:0]  O_PRICE,
    output logic [SEL_W-1:0]  O_SEL,
    output logic              O_VEND,
    output logic              O_SUCCESS,
    output logic [VAL_W-1:0]  O_CHANGE,
    output logic              O_COIN_OUT_VALID,
    output logic [VAL_W-1:0]  O_COIN_OUT_VAL,
    output logic              O_BUSY
);
    localparam int N_SEL = N_ROWS * N_COLS;
    localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HAVE_ROW = 3'd1;
    localparam logic [2:0] ST_CHECK    = 3'd2;
    localparam logic [2:0] ST_VEND     = 3'd3;
    localparam logic [2:0] ST_CHANGE   = 3'd4;

    logic [2:0]       state_reg, state_next;
    logic [VAL_W-1:0] credit_reg, credit_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [VAL_W-1:0] price_reg, price_next;
    logic [SEL_W-1:0] sel_out_reg, sel_out_next;
    logic [VAL_W-1:0] change_reg, change_next;
    logic [VAL_W-1:0] rem_reg, rem_next;
    logic [VAL_W-1:0] price_tab [N_SEL];

    logic             row_ok, col_ok, coin_ok;
    logic [ROW_W-1:0] row_idx;
    logic [COL_W-1:0] col_idx;
    logic [VAL_W:0]   coin_sum;
    logic [VAL_W-1:0] credit_add, vend_rem, coin_den;

    function automatic logic [ROW_W-1:0] row_index(input logic [N_ROWS-1:0] v);
        logic [ROW_W-1:0] idx = '0;
        for (int i = 0; i < N_ROWS; i++)
            if (v[i]) idx = ROW_W'(i);
        return idx;
    endfunction

    function automatic logic [COL_W-1:0] col_index(input logic [N_COLS-1:0] v);
        logic [COL_W-1:0] idx = '0;
        for (int i = 0; i < N_COLS; i++)
            if (v[i]) idx = COL_W'(i);
        return idx;
    endfunction

    // Largest hopper denomination not exceeding the remaining change.
    function automatic logic [VAL_W-1:0] denom(input logic [VAL_W-1:0] r);
        if (r >= VAL_W'(100))     return VAL_W'(100);
        else if (r >= VAL_W'(25)) return VAL_W'(25);
        else if (r >= VAL_W'(10)) return VAL_W'(10);
        else if (r >= VAL_W'(5))  return VAL_W'(5);
        else if (r >= VAL_W'(1))  return VAL_W'(1);
        else                      return '0;
    endfunction

    assign row_ok     = $onehot(I_ROW);
    assign col_ok     = $onehot(I_COL);
    assign row_idx    = row_index(I_ROW);
    assign col_idx    = col_index(I_COL);
    assign coin_ok    = I_COIN_VALID && (state_reg == ST_IDLE || state_reg == ST_HAVE_ROW ||
                                         state_reg == ST_CHECK);
    assign coin_sum   = {1'b0, credit_reg} + {1'b0, I_COIN_VAL};
    assign credit_add = !I_COIN_VALID ? credit_reg :
                        (coin_sum[VAL_W] ? {VAL_W{1'b1}} : coin_sum[VAL_W-1:0]);
    assign vend_rem   = credit_reg - price_reg;
    assign coin_den   = denom(rem_reg);

    always_comb begin
        state_next   = state_reg;
        credit_next  = coin_ok ? credit_add : credit_reg;
        row_next     = row_reg;
        timer_next   = timer_reg;
        sel_next     = sel_reg;
        price_next   = price_reg;
        sel_out_next = sel_out_reg;
        change_next  = change_reg;
        rem_next     = rem_reg;
        case (state_reg)
            ST_IDLE, ST_HAVE_ROW: begin
                // Cancel outranks any key pressed in the same cycle.
                if (I_CANCEL) begin
                    if (credit_reg != '0) begin
                        rem_next    = credit_add;
                        change_next = credit_add;
                        credit_next = '0;
                        state_next  = ST_CHANGE;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (row_ok) begin
                    row_next   = row_idx;
                    timer_next = '0;
                    state_next = ST_HAVE_ROW;
                end else if (state_reg == ST_HAVE_ROW) begin
                    if (col_ok) begin
                        sel_next   = SEL_W'(int'(row_reg) * N_COLS + int'(col_idx));
                        state_next = ST_CHECK;
                    end else if (timer_reg == TMR_W'(TIMEOUT_CYC - 1)) begin
                        state_next = ST_IDLE;
                    end else begin
                        timer_next = timer_reg + TMR_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                price_next = price_tab[sel_reg];
                state_next = (credit_reg >= price_tab[sel_reg]) ? ST_VEND : ST_IDLE;
            end
            ST_VEND: begin
                sel_out_next = sel_reg;
                change_next  = vend_rem;
                rem_next     = vend_rem;
                credit_next  = '0;
                state_next   = (vend_rem == '0) ? ST_IDLE : ST_CHANGE;
            end
            ST_CHANGE: begin
                if (I_COIN_OUT_READY) begin
                    rem_next = rem_reg - coin_den;
                    if (rem_reg == coin_den) state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_reg   <= ST_IDLE;
            credit_reg  <= '0;
            row_reg     <= '0;
            timer_reg   <= '0;
            sel_reg     <= '0;
            price_reg   <= '0;
            sel_out_reg <= '0;
            change_reg  <= '0;
            rem_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            credit_reg  <= credit_next;
            row_reg     <= row_next;
            timer_reg   <= timer_next;
            sel_reg     <= sel_next;
            price_reg   <= price_next;
            sel_out_reg <= sel_out_next;
            change_reg  <= change_next;
            rem_reg     <= rem_next;
        end
    end

    // Price entries are plain registers so reset can restore the default price.
    for (genvar gi = 0; gi < N_SEL; gi++) begin : g_price
        always_ff @(posedge I_CLK or posedge I_RESET) begin
            if (I_RESET)
                price_tab[gi] <= VAL_W'(DEFAULT_PRICE);
            else if (I_PW_EN && I_PW_ADDR == SEL_W'(gi))
                price_tab[gi] <= I_PW_DATA;
        end
    end

    assign O_CREDIT         = credit_reg;
    assign O_PRICE          = price_reg;
    assign O_SEL            = sel_out_reg;
    assign O_CHANGE         = change_reg;
    assign O_VEND           = (state_reg == ST_VEND);
    assign O_SUCCESS        = (state_reg == ST_VEND);
    assign O_COIN_OUT_VALID = (state_reg == ST_CHANGE);
    assign O_COIN_OUT_VAL   = (state_reg == ST_CHANGE) ? coin_den : '0;
    assign O_BUSY           = (state_reg == ST_VEND) || (state_reg == ST_CHANGE);
endmodule

// File: tb/tb_vending_machine_gen2.sv
// Randomised and directed bench for vending_machine_gen2: a transaction-level model queues
// expected per-cycle outputs and change coins; a negedge monitor pops and compares them.
module tb_vending_machine_gen2;
    localparam int NR = 4, NC = 4, VW = 16, DP = 100, TMO = 40, SW = 4, NS = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] I_ROW;
    logic [NC-1:0] I_COL;
    logic          I_COIN_VALID, I_CANCEL, I_PW_EN, I_COIN_OUT_READY;
    logic [VW-1:0] I_COIN_VAL, I_PW_DATA;
    logic [SW-1:0] I_PW_ADDR;
    logic [VW-1:0] O_CREDIT, O_PRICE, O_CHANGE, O_COIN_OUT_VAL;
    logic [SW-1:0] O_SEL;
    logic          O_VEND, O_SUCCESS, O_COIN_OUT_VALID, O_BUSY;

    always #5 clk = ~clk;

    vending_machine_gen2 #(.N_ROWS(NR), .N_COLS(NC), .VAL_W(VW), .DEFAULT_PRICE(DP),
                           .TIMEOUT_CYC(TMO)) dut (
        .I_CLK(clk), .I_RESET(rst), .I_ROW(I_ROW), .I_COL(I_COL),
        .I_COIN_VALID(I_COIN_VALID), .I_COIN_VAL(I_COIN_VAL), .I_CANCEL(I_CANCEL),
        .I_PW_EN(I_PW_EN), .I_PW_ADDR(I_PW_ADDR), .I_PW_DATA(I_PW_DATA),
        .I_COIN_OUT_READY(I_COIN_OUT_READY), .O_CREDIT(O_CREDIT), .O_PRICE(O_PRICE),
        .O_SEL(O_SEL), .O_VEND(O_VEND), .O_SUCCESS(O_SUCCESS), .O_CHANGE(O_CHANGE),
        .O_COIN_OUT_VALID(O_COIN_OUT_VALID), .O_COIN_OUT_VAL(O_COIN_OUT_VAL), .O_BUSY(O_BUSY)
    );

    typedef struct {
        int cyc; int credit; int price; int sel; int change;
        int vend; int busy; int cvalid; int cval;
    } exp_t;

    typedef enum {P_IDLE, P_ROW, P_CHECK, P_VEND, P_PAY} phase_t;

    exp_t   exp_q[$];
    int     coin_q[$];
    exp_t   mon_e;
    int     n_cmp = 0, n_bad = 0, cyc = 0;
    bit     mon_en = 1'b0, rand_ready = 1'b0;

    // Reference model: what the machine should look like after the coming clock edge.
    phase_t ph;
    int     m_credit, m_row, m_wait, m_sel, m_price_out, m_sel_out, m_change_out;
    int     m_tab[NS];
    int     m_pay[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int key_index(input logic [3:0] v);
        int cnt = 0, ix = -1;
        for (int i = 0; i < 4; i++) if (v[i]) begin cnt++; ix = i; end
        return (cnt == 1) ? ix : -1;
    endfunction

    task automatic model_reset();
        ph = P_IDLE; m_credit = 0; m_row = 0; m_wait = 0; m_sel = 0;
        m_price_out = 0; m_sel_out = 0; m_change_out = 0;
        for (int i = 0; i < NS; i++) m_tab[i] = DP;
        m_pay.delete();
    endtask

    // Greedy breakdown of an amount; every coin is also queued for the handshake checker.
    task automatic make_change(input int amt);
        int d[5] = '{100, 25, 10, 5, 1};
        int left = amt;
        m_change_out = amt;
        m_pay.delete();
        for (int k = 0; k < 5; k++)
            while (left >= d[k]) begin
                m_pay.push_back(d[k]); coin_q.push_back(d[k]); left -= d[k];
            end
        ph = (amt == 0) ? P_IDLE : P_PAY;
    endtask

    task automatic model_step();
        int ri, ci, with_coin, r;
        exp_t e;
        ri = key_index(I_ROW);
        ci = key_index(I_COL);
        with_coin = I_COIN_VALID ? m_credit + int'(I_COIN_VAL) : m_credit;
        if (with_coin > 65535) with_coin = 65535;
        case (ph)
            P_IDLE, P_ROW: begin
                if (I_CANCEL) begin
                    if (m_credit > 0) begin m_credit = 0; make_change(with_coin); end
                    else begin m_credit = with_coin; ph = P_IDLE; end
                end else begin
                    m_credit = with_coin;
                    if (ri >= 0) begin ph = P_ROW; m_row = ri; m_wait = 0; end
                    else if (ph == P_ROW) begin
                        if (ci >= 0) begin m_sel = m_row * NC + ci; ph = P_CHECK; end
                        else begin m_wait++; if (m_wait == TMO) ph = P_IDLE; end
                    end
                end
            end
            P_CHECK: begin
                m_price_out = m_tab[m_sel];
                ph = (m_credit >= m_price_out) ? P_VEND : P_IDLE;
                m_credit = with_coin;
            end
            P_VEND: begin
                r = m_credit - m_price_out;
                m_sel_out = m_sel;
                m_credit = 0;
                make_change(r);
            end
            P_PAY: if (I_COIN_OUT_READY) begin
                void'(m_pay.pop_front());
                if (m_pay.size() == 0) ph = P_IDLE;
            end
            default: ph = P_IDLE;
        endcase
        if (I_PW_EN) m_tab[I_PW_ADDR] = int'(I_PW_DATA);
        e.cyc = cyc + 1; e.credit = m_credit; e.price = m_price_out; e.sel = m_sel_out;
        e.change = m_change_out; e.vend = (ph == P_VEND);
        e.busy = (ph == P_VEND || ph == P_PAY); e.cvalid = (ph == P_PAY);
        e.cval = (ph == P_PAY) ? m_pay[0] : 0;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        if (rand_ready) I_COIN_OUT_READY = ($urandom_range(0, 2) != 0);
        model_step();
        @(posedge clk);
        cyc++;
        #1;
        I_ROW = '0; I_COL = '0; I_COIN_VALID = 1'b0; I_CANCEL = 1'b0; I_PW_EN = 1'b0;
    endtask

    task automatic coin(input int v);   I_COIN_VALID = 1'b1; I_COIN_VAL = VW'(v); tick(); endtask
    task automatic row(input int r);    I_ROW = NR'(1 << r); tick(); endtask
    task automatic col(input int c);    I_COL = NC'(1 << c); tick(); endtask
    task automatic cancel();            I_CANCEL = 1'b1; tick(); endtask
    task automatic idle(input int n);   repeat (n) tick(); endtask
    task automatic pw(input int a, input int d);
        I_PW_EN = 1'b1; I_PW_ADDR = SW'(a); I_PW_DATA = VW'(d); tick();
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && ph != P_IDLE; i++) tick();
        check("drain_busy", O_BUSY, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_credit"}, O_CREDIT, 0);   check({tag, "_price"}, O_PRICE, 0);
        check({tag, "_sel"}, O_SEL, 0);         check({tag, "_vend"}, O_VEND, 0);
        check({tag, "_success"}, O_SUCCESS, 0); check({tag, "_change"}, O_CHANGE, 0);
        check({tag, "_cvalid"}, O_COIN_OUT_VALID, 0);
        check({tag, "_cval"}, O_COIN_OUT_VAL, 0); check({tag, "_busy"}, O_BUSY, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("stale_expect", exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_e = exp_q.pop_front();
                check("credit", O_CREDIT, mon_e.credit);  check("price", O_PRICE, mon_e.price);
                check("sel", O_SEL, mon_e.sel);           check("change", O_CHANGE, mon_e.change);
                check("vend", O_VEND, mon_e.vend);        check("success", O_SUCCESS, mon_e.vend);
                check("busy", O_BUSY, mon_e.busy);
                check("coin_valid", O_COIN_OUT_VALID, mon_e.cvalid);
                check("coin_val", O_COIN_OUT_VAL, mon_e.cval);
                if (O_VEND) $display("cycle %0d: vend at price %0d", cyc, O_PRICE);
            end
            if (O_COIN_OUT_VALID && I_COIN_OUT_READY) begin
                if (coin_q.size() == 0) check("unexpected_coin", O_COIN_OUT_VAL, -1);
                else begin
                    check("handshake_coin", O_COIN_OUT_VAL, coin_q.pop_front());
                    $display("cycle %0d: change coin %0d", cyc, O_COIN_OUT_VAL);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int denoms[5] = '{1, 5, 10, 25, 100};
        int k;
        rst = 1'b1; I_ROW = '0; I_COL = '0; I_COIN_VALID = 1'b0; I_COIN_VAL = '0;
        I_CANCEL = 1'b0; I_PW_EN = 1'b0; I_PW_ADDR = '0; I_PW_DATA = '0; I_COIN_OUT_READY = 1'b1;
        model_reset();
        #12;
        check_all_zero("reset");
        @(posedge clk); cyc++; #1;
        rst = 1'b0; mon_en = 1'b1;

        // Exact payment.
        coin(100); row(0); col(0); tick();
        check("exact_vend", O_VEND, 1); check("exact_success", O_SUCCESS, 1);
        tick();
        check("exact_sel", O_SEL, 0); check("exact_change", O_CHANGE, 0);
        check("exact_credit", O_CREDIT, 0);

        // Insufficient credit leaves the price on display.
        pw(5, 250); coin(100); coin(100); row(1); col(1); tick();
        check("short_price", O_PRICE, 250); check("short_credit", O_CREDIT, 200);
        check("short_vend", O_VEND, 0);
        cancel(); drain();

        // Row override and paid change under a toggling hopper.
        pw(15, 200);
        repeat (4) coin(100);
        row(0); row(1); row(3); col(3); tick(); tick();
        check("override_sel", O_SEL, 15); check("override_change", O_CHANGE, 200);
        rand_ready = 1'b1; drain(); rand_ready = 1'b0; I_COIN_OUT_READY = 1'b1;

        // Greedy refund of 141.
        coin(100); coin(25); coin(10); coin(5); coin(1);
        check("greedy_credit", O_CREDIT, 141);
        cancel();
        check("greedy_change", O_CHANGE, 141);
        drain();

        // Keypad timeout keeps credit and ignores the late column.
        coin(25); row(2); idle(TMO); col(0); tick();
        check("timeout_vend", O_VEND, 0); check("timeout_credit", O_CREDIT, 25);
        check("timeout_busy", O_BUSY, 0);
        cancel(); drain();

        // Asynchronous reset while change is being paid.
        coin(100); coin(100); coin(10); I_COIN_OUT_READY = 1'b0; cancel(); idle(3);
        check("prereset_cvalid", O_COIN_OUT_VALID, 1);
        rst = 1'b1; #1;
        check_all_zero("midreset");
        exp_q.delete(); coin_q.delete(); model_reset();
        repeat (2) begin @(posedge clk); cyc++; end
        #1; rst = 1'b0; I_COIN_OUT_READY = 1'b1;
        coin(100); row(1); col(1); tick();
        check("postreset_vend", O_VEND, 1); check("postreset_price", O_PRICE, 100);
        tick();

        // Credit saturation paid off exactly.
        pw(3, 65535); coin(65000); coin(1000);
        check("sat_credit", O_CREDIT, 65535);
        row(0); col(3); tick();
        check("sat_vend", O_VEND, 1);
        tick();
        check("sat_change", O_CHANGE, 0);

        // Random traffic.
        rand_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 12) begin
                I_COIN_VALID = 1'b1; I_COIN_VAL = VW'(denoms[$urandom_range(0, 4)]);
            end
            k = $urandom_range(0, 99);
            if (k < 12)      I_ROW = NR'(1 << $urandom_range(0, NR - 1));
            else if (k < 15) I_ROW = 4'b0110;
            else if (k < 27) I_COL = NC'(1 << $urandom_range(0, NC - 1));
            else if (k < 30) I_COL = 4'b1001;
            if ($urandom_range(0, 99) < 4) I_CANCEL = 1'b1;
            if ($urandom_range(0, 99) < 5) begin
                I_PW_EN = 1'b1; I_PW_ADDR = SW'($urandom_range(0, NS - 1));
                I_PW_DATA = VW'($urandom_range(0, 400));
            end
            tick();
        end
        drain();
        rand_ready = 1'b0; I_COIN_OUT_READY = 1'b1;
        tick();
        @(negedge clk); #1;
        check("coins_left", coin_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
